// File: rtl/simmem_pkg.sv
// Shared definitions for the simulated-memory DRAM timing engine.
// Holds the timing constants and bank geometry, the derived widths, the
// request bundle type and the per-bank slot state encoding.
package simmem_pkg;

  localparam int NumBanks          = 4;
  localparam int AddrWidth         = 16;
  localparam int RowBufferLenWidth = 8;
  localparam int IDWidth           = 4;
  localparam int RowHitCost        = 10;
  localparam int PrechargeCost     = 50;
  localparam int ActivationCost    = 45;
  localparam int MaxBurstLen       = 4;
  localparam bit ClosedPageDefault = 1'b0;

  localparam int BankIdxWidth = $clog2(NumBanks);
  localparam int RowWidth     = AddrWidth - RowBufferLenWidth - BankIdxWidth;
  localparam int CostWidth    =
    $clog2(PrechargeCost + ActivationCost + RowHitCost * MaxBurstLen + 1);

  typedef struct packed {
    logic                 is_write;
    logic [IDWidth-1:0]   id;
    logic [7:0]           len;
    logic [AddrWidth-1:0] addr;
  } dram_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_state_e;

endpackage

// File: rtl/simmem_dram_timing_engine_if.sv
// Request / completion bundle of the DRAM timing engine.
//   req_*  : request channel (valid/ready), byte address, AXI burst length,
//            AXI ID and direction.
//   done_* : completion channel (valid/ready), ID, direction and bank.
// master drives requests and accepts completions; slave is the engine.
interface simmem_dram_timing_engine_if;
  import simmem_pkg::*;

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [AddrWidth-1:0]    req_addr_i;
  logic [7:0]              req_len_i;
  logic [IDWidth-1:0]      req_id_i;
  logic                    req_is_write_i;
  logic                    done_valid_o;
  logic                    done_ready_i;
  logic [IDWidth-1:0]      done_id_o;
  logic                    done_is_write_o;
  logic [BankIdxWidth-1:0] done_bank_o;

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_id_i, req_is_write_i,
    output done_ready_i,
    input  req_ready_o, done_valid_o, done_id_o, done_is_write_o, done_bank_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_id_i, req_is_write_i,
    input  done_ready_i,
    output req_ready_o, done_valid_o, done_id_o, done_is_write_o, done_bank_o
  );

endinterface

// File: rtl/simmem_dram_bank.sv
// One DRAM bank: row-buffer state, access-cost calculation and the slot
// that holds an accepted request until its cost has elapsed.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   accept_i       : request handshake targeting this bank (only while idle)
//   row_i, len_i   : decoded row and AXI burst length of that request
//   id_i, is_write_i : request tag and direction, latched on accept
//   release_i      : completion handshake for this bank
//   idle_o, done_o : slot state flags
//   id_o, is_write_o : tag and direction of the held request
module simmem_dram_bank
  import simmem_pkg::*;
#(
  parameter bit ClosedPage = ClosedPageDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                accept_i,
  input  logic [RowWidth-1:0] row_i,
  input  logic [7:0]          len_i,
  input  logic [IDWidth-1:0]  id_i,
  input  logic                is_write_i,
  input  logic                release_i,
  output logic                idle_o,
  output logic                done_o,
  output logic [IDWidth-1:0]  id_o,
  output logic                is_write_o
);

  slot_state_e          state_q, state_d;
  logic [CostWidth-1:0] cnt_q, cnt_d;
  logic [CostWidth-1:0] cost;
  logic [8:0]           beats;
  logic                 open_q;
  logic [RowWidth-1:0]  row_q;
  logic [IDWidth-1:0]   id_q;
  logic                 wr_q;

  // Beat count saturates at MaxBurstLen; 9 bits so len 255 cannot wrap to 0.
  function automatic logic [8:0] clamp_beats(input logic [7:0] len);
    logic [8:0] b;
    b = {1'b0, len} + 9'd1;
    if (b > 9'(MaxBurstLen)) b = 9'(MaxBurstLen);
    return b;
  endfunction

  assign beats = clamp_beats(len_i);

  always_comb begin
    cost = CostWidth'(RowHitCost) * CostWidth'(beats);
    if (!open_q)
      cost = cost + CostWidth'(ActivationCost);
    else if (row_q != row_i)
      cost = cost + CostWidth'(PrechargeCost + ActivationCost);
  end

  // The counter is loaded with the cost in the accept cycle; leaving BUSY as
  // it steps from 2 to 1 puts the slot in DONE exactly cost cycles later.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept_i) begin
        state_d = BUSY;
        cnt_d   = cost;
      end
      BUSY: begin
        cnt_d = cnt_q - CostWidth'(1);
        if (cnt_q == CostWidth'(2)) state_d = DONE;
      end
      DONE: if (release_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      open_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_i && !ClosedPage) open_q <= 1'b1;
    end
  end

  // Payload registers carry no reset; they are only read while the slot
  // or open flag says they are meaningful.
  always_ff @(posedge clk_i) begin
    if (accept_i) begin
      id_q <= id_i;
      wr_q <= is_write_i;
      if (!ClosedPage) row_q <= row_i;
    end
  end

  assign idle_o     = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign id_o       = id_q;
  assign is_write_o = wr_q;

endmodule

// File: rtl/simmem_dram_timing_engine.sv
// Multi-bank DRAM latency model. Decodes bank and row from each request,
// hands it to that bank's slot, and emits one completion per finished
// request through a round-robin arbiter whose grant is held until taken.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : request channel in, completion channel out
// ClosedPage = 1 auto-precharges after every access.
module simmem_dram_timing_engine
  import simmem_pkg::*;
#(
  parameter bit ClosedPage = ClosedPageDefault
) (
  input logic                        clk_i,
  input logic                        rst_i,
  simmem_dram_timing_engine_if.slave bus
);

  dram_req_t               req;
  logic [BankIdxWidth-1:0] req_bank;
  logic [RowWidth-1:0]     req_row;
  logic                    accept;
  logic                    unused_column;

  logic [NumBanks-1:0]     idle;
  logic [NumBanks-1:0]     done;
  logic [IDWidth-1:0]      ids [NumBanks];
  logic                    wrs [NumBanks];

  logic [BankIdxWidth-1:0] ptr_q;
  logic                    lock_q;
  logic [BankIdxWidth-1:0] lock_idx_q;
  logic [BankIdxWidth-1:0] pick;
  logic [BankIdxWidth-1:0] idx;
  logic                    found;
  logic [BankIdxWidth-1:0] grant;
  logic                    done_valid;
  logic                    hs;

  assign req = '{is_write: bus.req_is_write_i, id: bus.req_id_i,
                 len: bus.req_len_i, addr: bus.req_addr_i};

  assign req_bank      = req.addr[RowBufferLenWidth +: BankIdxWidth];
  assign req_row       = req.addr[AddrWidth-1 -: RowWidth];
  assign unused_column = ^req.addr[RowBufferLenWidth-1:0];

  // Ready reflects only the current slot state, so a slot completing this
  // cycle is not refilled until the next one.
  assign bus.req_ready_o = idle[req_bank];
  assign accept          = bus.req_valid_i & bus.req_ready_o;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    simmem_dram_bank #(.ClosedPage(ClosedPage)) u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .accept_i   (accept && (req_bank == BankIdxWidth'(b))),
      .row_i      (req_row),
      .len_i      (req.len),
      .id_i       (req.id),
      .is_write_i (req.is_write),
      .release_i  (hs && (grant == BankIdxWidth'(b))),
      .idle_o     (idle[b]),
      .done_o     (done[b]),
      .id_o       (ids[b]),
      .is_write_o (wrs[b])
    );
  end

  // First DONE slot at or after the pointer, wrapping (NumBanks is a power
  // of two, so the index addition wraps naturally).
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 0; k < NumBanks; k++) begin
      idx = ptr_q + BankIdxWidth'(k);
      if (!found && done[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // A locked grant keeps the completion stable while the consumer stalls;
  // done_valid never looks at done_ready.
  assign grant      = lock_q ? lock_idx_q : pick;
  assign done_valid = lock_q | found;
  assign hs         = done_valid & bus.done_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      ptr_q  <= grant + BankIdxWidth'(1);
      lock_q <= 1'b0;
    end else if (done_valid) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant;
    end
  end

  assign bus.done_valid_o    = done_valid;
  assign bus.done_id_o       = ids[grant];
  assign bus.done_is_write_o = wrs[grant];
  assign bus.done_bank_o     = grant;

endmodule

// File: tb/tb_simmem_dram_timing_engine.sv
// Bench for simmem_dram_timing_engine: one open-page and one closed-page
// instance, each checked every cycle against a cycle-count model of bank
// slots, row buffers and the round-robin completion order.
module tb_simmem_dram_timing_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_valid [2];
  logic [15:0] i_addr  [2];
  logic [7:0]  i_len   [2];
  logic [3:0]  i_id    [2];
  logic        i_wr    [2];
  logic        i_drdy  [2];
  logic        o_ready [2];
  logic        o_valid [2];
  logic [3:0]  o_id    [2];
  logic        o_wr    [2];
  logic [1:0]  o_bank  [2];

  simmem_dram_timing_engine_if bus0();
  simmem_dram_timing_engine_if bus1();

  simmem_dram_timing_engine #(.ClosedPage(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
  simmem_dram_timing_engine #(.ClosedPage(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

  assign bus0.req_valid_i = i_valid[0];  assign bus1.req_valid_i = i_valid[1];
  assign bus0.req_addr_i = i_addr[0];    assign bus1.req_addr_i = i_addr[1];
  assign bus0.req_len_i = i_len[0];      assign bus1.req_len_i = i_len[1];
  assign bus0.req_id_i = i_id[0];        assign bus1.req_id_i = i_id[1];
  assign bus0.req_is_write_i = i_wr[0];  assign bus1.req_is_write_i = i_wr[1];
  assign bus0.done_ready_i = i_drdy[0];  assign bus1.done_ready_i = i_drdy[1];
  assign o_ready[0] = bus0.req_ready_o;  assign o_ready[1] = bus1.req_ready_o;
  assign o_valid[0] = bus0.done_valid_o; assign o_valid[1] = bus1.done_valid_o;
  assign o_id[0] = bus0.done_id_o;       assign o_id[1] = bus1.done_id_o;
  assign o_wr[0] = bus0.done_is_write_o; assign o_wr[1] = bus1.done_is_write_o;
  assign o_bank[0] = bus0.done_bank_o;   assign o_bank[1] = bus1.done_bank_o;

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Model state: unit 0 is open-page, unit 1 closed-page.
  bit         m_busy    [2][4];
  int         m_done_at [2][4];
  logic [3:0] m_id      [2][4];
  logic       m_wr      [2][4];
  bit         m_open    [2][4];
  int         m_row     [2][4];
  int         m_ptr     [2];
  bit         m_locked  [2];
  int         m_lock_bank [2];
  int         m_last_cost [2];
  int         rec [2][16];   // cycle a given ID first appeared on done_*

  function automatic void model_reset(int u);
    for (int b = 0; b < 4; b++) begin
      m_busy[u][b] = 1'b0;
      m_open[u][b] = 1'b0;
    end
    m_ptr[u] = 0;
    m_locked[u] = 1'b0;
    m_lock_bank[u] = 0;
  endfunction

  function automatic int model_cost(int u, logic [15:0] a, logic [7:0] l);
    int beats, b, r;
    beats = int'(l) + 1;
    if (beats > 4) beats = 4;
    b = int'(a[9:8]);
    r = int'(a[15:10]);
    if (!m_open[u][b]) return 45 + 10 * beats;
    if (m_row[u][b] != r) return 50 + 45 + 10 * beats;
    return 10 * beats;
  endfunction

  function automatic void model_cycle(int u);
    bit ev, er;
    int eb, rb, b, cost;
    ev = 1'b0;
    eb = 0;
    if (m_locked[u]) begin
      ev = 1'b1;
      eb = m_lock_bank[u];
    end else begin
      for (int k = 0; k < 4; k++) begin
        b = (m_ptr[u] + k) % 4;
        if (!ev && m_busy[u][b] && cyc >= m_done_at[u][b]) begin
          ev = 1'b1;
          eb = b;
        end
      end
    end
    rb = int'(i_addr[u][9:8]);
    er = !m_busy[u][rb];
    check($sformatf("u%0d_req_ready", u), int'(o_ready[u]), int'(er));
    check($sformatf("u%0d_done_valid", u), int'(o_valid[u]), int'(ev));
    if (ev && o_valid[u]) begin
      check($sformatf("u%0d_done_bank", u), int'(o_bank[u]), eb);
      check($sformatf("u%0d_done_id", u), int'(o_id[u]), int'(m_id[u][eb]));
      check($sformatf("u%0d_done_wr", u), int'(o_wr[u]), int'(m_wr[u][eb]));
    end
    if (o_valid[u] && rec[u][o_id[u]] < 0) rec[u][o_id[u]] = cyc;
    if (ev && i_drdy[u]) begin
      m_busy[u][eb] = 1'b0;
      m_ptr[u] = (eb + 1) % 4;
      m_locked[u] = 1'b0;
    end else if (ev) begin
      m_locked[u] = 1'b1;
      m_lock_bank[u] = eb;
    end
    if (i_valid[u] && er) begin
      cost = model_cost(u, i_addr[u], i_len[u]);
      m_last_cost[u] = cost;
      m_busy[u][rb] = 1'b1;
      m_done_at[u][rb] = cyc + cost;
      m_id[u][rb] = i_id[u];
      m_wr[u][rb] = i_wr[u];
      if (u == 0) begin
        m_open[u][rb] = 1'b1;
        m_row[u][rb] = int'(i_addr[u][15:10]);
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) model_reset(u);
      else model_cycle(u);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] l, input logic [3:0] id,
                      input logic w, output int ta0, output int ta1);
    int n;
    for (int u = 0; u < 2; u++) begin
      i_addr[u] = a; i_len[u] = l; i_id[u] = id; i_wr[u] = w; i_valid[u] = 1'b1;
      rec[u][id] = -1;
    end
    ta0 = -1; ta1 = -1; n = 0;
    while ((i_valid[0] || i_valid[1]) && n < 400) begin
      @(negedge clk);
      if (i_valid[0] && o_ready[0]) ta0 = cyc;
      if (i_valid[1] && o_ready[1]) ta1 = cyc;
      step();
      if (ta0 >= 0) i_valid[0] = 1'b0;
      if (ta1 >= 0) i_valid[1] = 1'b0;
      n++;
    end
    check($sformatf("accept_id%0d", id), int'(ta0 >= 0 && ta1 >= 0), 1);
    i_valid[0] = 1'b0;
    i_valid[1] = 1'b0;
  endtask

  task automatic wait_id(input int u, input int id, input int budget);
    int n;
    n = 0;
    while (rec[u][id] < 0 && n < budget) begin
      step();
      n++;
    end
    check($sformatf("u%0d_completion_id%0d", u, id), int'(rec[u][id] >= 0), 1);
  endtask

  int t0, t1, s0, s1, c_pres, r;

  initial begin
    for (int u = 0; u < 2; u++) begin
      i_valid[u] = 1'b0; i_addr[u] = '0; i_len[u] = '0; i_id[u] = '0;
      i_wr[u] = 1'b0; i_drdy[u] = 1'b1;
      m_last_cost[u] = 0;
      for (int k = 0; k < 16; k++) rec[u][k] = -1;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready_u0", int'(o_ready[0]), 1);
    check("reset_ready_u1", int'(o_ready[1]), 1);
    check("reset_valid_u0", int'(o_valid[0]), 0);
    check("reset_valid_u1", int'(o_valid[1]), 0);
    step();

    // Closed bank 0: 45 + 10
    send(16'h0000, 8'd0, 4'd1, 1'b0, t0, t1);
    check("model_cost_id1", m_last_cost[0], 55);
    wait_id(0, 1, 300); wait_id(1, 1, 300);
    check("u0_lat_id1", rec[0][1] - t0, 55);
    check("u1_lat_id1", rec[1][1] - t1, 55);

    // Same row, 4 beats: hit 40 open-page, 85 closed-page
    send(16'h0004, 8'd3, 4'd2, 1'b1, t0, t1);
    wait_id(0, 2, 300); wait_id(1, 2, 300);
    check("u0_lat_id2", rec[0][2] - t0, 40);
    check("u1_lat_id2", rec[1][2] - t1, 85);

    // Row conflict in bank 0, then bank 0 refuses while bank 1 accepts
    send(16'h0400, 8'd0, 4'd3, 1'b0, t0, t1);
    check("model_cost_id3", m_last_cost[0], 105);
    i_addr[0] = 16'h0408; i_addr[1] = 16'h0408;
    @(negedge clk);
    check("u0_bank0_busy_ready", int'(o_ready[0]), 0);
    check("u1_bank0_busy_ready", int'(o_ready[1]), 0);
    step();
    c_pres = cyc;
    send(16'h0100, 8'd0, 4'd4, 1'b1, s0, s1);
    check("u0_bank1_immediate", s0, c_pres);
    check("u1_bank1_immediate", s1, c_pres);
    wait_id(0, 4, 300); wait_id(1, 4, 300);
    wait_id(0, 3, 300); wait_id(1, 3, 300);
    check("u0_lat_id3", rec[0][3] - t0, 105);
    check("u1_lat_id3", rec[1][3] - t1, 55);
    check("u0_lat_id4", rec[0][4] - s0, 55);

    // len=7 clamps to 4 beats
    send(16'h0410, 8'd7, 4'd5, 1'b0, t0, t1);
    check("model_cost_id5_u0", m_last_cost[0], 40);
    check("model_cost_id5_u1", m_last_cost[1], 85);
    wait_id(0, 5, 300); wait_id(1, 5, 300);
    check("u0_lat_id5", rec[0][5] - t0, 40);
    check("u1_lat_id5", rec[1][5] - t1, 85);

    // Bank 3 completion leaves the pointer at 0
    send(16'h0300, 8'd0, 4'd6, 1'b0, t0, t1);
    wait_id(0, 6, 300); wait_id(1, 6, 300);
    step();
    check("model_ptr_after_bank3", m_ptr[0], 0);

    // Banks 0 and 1 finish together (t+20 open-page, t+65 closed-page)
    i_drdy[0] = 1'b0; i_drdy[1] = 1'b0;
    send(16'h0400, 8'd1, 4'd7, 1'b1, t0, t1);
    while (cyc < t0 + 10) step();
    send(16'h0100, 8'd0, 4'd8, 1'b0, s0, s1);
    wait_id(0, 7, 300);
    check("u0_lat_id7", rec[0][7] - t0, 20);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("hold_valid", int'(o_valid[0]), 1);
      check("hold_bank", int'(o_bank[0]), 0);
      check("hold_id", int'(o_id[0]), 7);
      step();
    end
    i_drdy[0] = 1'b1; i_drdy[1] = 1'b1;
    @(negedge clk);
    check("hs_bank", int'(o_bank[0]), 0);
    step();
    i_drdy[0] = 1'b0; i_drdy[1] = 1'b0;
    @(negedge clk);
    check("next_valid", int'(o_valid[0]), 1);
    check("next_bank", int'(o_bank[0]), 1);
    check("next_id", int'(o_id[0]), 8);
    step();
    i_drdy[0] = 1'b1; i_drdy[1] = 1'b1;
    step();
    check("model_ptr_after_bank1", m_ptr[0], 2);
    wait_id(1, 7, 300); wait_id(1, 8, 300);
    check("u1_lat_id7", rec[1][7] - t1, 65);
    check("u1_id8_follows", rec[1][8] - rec[1][7], 1);

    // Reset while bank 2 is busy drops the request
    send(16'h0200, 8'd0, 4'd9, 1'b0, t0, t1);
    repeat (10) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (80) step();
    check("u0_dropped_id9", rec[0][9], -1);
    check("u1_dropped_id9", rec[1][9], -1);
    send(16'h0200, 8'd0, 4'd10, 1'b0, t0, t1);
    wait_id(0, 10, 300); wait_id(1, 10, 300);
    check("u0_lat_after_reset", rec[0][10] - t0, 55);
    check("u1_lat_after_reset", rec[1][10] - t1, 55);

    // Back-to-back same row: closed-page pays activation each time
    send(16'h0000, 8'd0, 4'd11, 1'b0, t0, t1);
    wait_id(0, 11, 300); wait_id(1, 11, 300);
    check("u1_lat_id11", rec[1][11] - t1, 55);
    send(16'h0000, 8'd0, 4'd12, 1'b1, t0, t1);
    wait_id(0, 12, 300); wait_id(1, 12, 300);
    check("u0_lat_id12", rec[0][12] - t0, 10);
    check("u1_lat_id12", rec[1][12] - t1, 55);

    // Randomized traffic, with one reset in the middle
    for (int n = 0; n < 2000; n++) begin
      for (int u = 0; u < 2; u++) begin
        i_valid[u] = ($urandom_range(0, 2) == 0);
        i_addr[u] = {6'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 8'($urandom)};
        r = int'($urandom_range(0, 3));
        i_len[u] = (r == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
        i_id[u] = 4'($urandom);
        i_wr[u] = 1'($urandom);
        i_drdy[u] = ($urandom_range(0, 3) != 0);
      end
      rst = (n == 1000 || n == 1001);
      step();
    end
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      i_valid[u] = 1'b0;
      i_drdy[u] = 1'b1;
    end
    repeat (300) step();
    @(negedge clk);
    check("drained_u0", int'(o_valid[0]), 0);
    check("drained_u1", int'(o_valid[1]), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
